// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw input and accepts a new level only after DEBOUNCE_CYCLES stable samples.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int CNT_WIDTH       = 4,
  parameter int GLITCH_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic                    dout,
  output logic                    rise,
  output logic                    fall,
  output logic                    busy,
  output logic [GLITCH_WIDTH-1:0] glitch_cnt
);
  localparam logic [1:0] S_LOW    = 2'd0;
  localparam logic [1:0] S_WAIT_H = 2'd1;
  localparam logic [1:0] S_HIGH   = 2'd2;
  localparam logic [1:0] S_WAIT_L = 2'd3;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [GLITCH_WIDTH-1:0] GMAX = '1;
  logic [SYNC_STAGES-1:0] sync;
  logic [1:0] state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [GLITCH_WIDTH-1:0] glitch_next;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign glitch_next = (glitch_cnt == GMAX) ? glitch_cnt : glitch_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      state <= S_LOW;
      cnt <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW: if (s) begin
          state <= S_WAIT_H;
          cnt <= ONE;
          busy <= 1'b1;
        end
        S_WAIT_H: if (!s) begin
          state <= S_LOW;
          cnt <= '0;
          busy <= 1'b0;
          glitch_cnt <= glitch_next;
        end else if (cnt == LAST) begin
          state <= S_HIGH;
          cnt <= '0;
          busy <= 1'b0;
          dout <= 1'b1;
          rise <= 1'b1;
        end else cnt <= cnt + 1'b1;
        S_HIGH: if (!s) begin
          state <= S_WAIT_L;
          cnt <= ONE;
          busy <= 1'b1;
        end
        S_WAIT_L: if (s) begin
          state <= S_HIGH;
          cnt <= '0;
          busy <= 1'b0;
          glitch_cnt <= glitch_next;
        end else if (cnt == LAST) begin
          state <= S_LOW;
          cnt <= '0;
          busy <= 1'b0;
          dout <= 1'b0;
          fall <= 1'b1;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed and random stimulus checked against a run-length model of the debouncer.
module tb_debounce_sync;
  localparam int SS = 2;
  localparam int DC = 5;
  localparam int GW = 8;
  localparam int GMAX = (1 << GW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;
  logic [GW-1:0] glitch_cnt;
  int checks = 0;
  int errors = 0;
  logic [SS-1:0] hist = '0;
  logic m_level = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int run = 0;
  int m_glitch = 0;
  debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(4), .GLITCH_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .busy(busy), .glitch_cnt(glitch_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist = '0;
    m_level = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    run = 0;
    m_glitch = 0;
  endtask
  // The model tracks how long the synchronised input has disagreed with the accepted level.
  task automatic tick();
    logic s;
    @(posedge clk);
    s = hist[SS-1];
    hist = {hist[SS-2:0], din};
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) model_reset();
    else if (s != m_level) begin
      run++;
      if (run == DC) begin
        m_level = s;
        m_rise = s;
        m_fall = !s;
        run = 0;
      end
    end else if (run > 0) begin
      run = 0;
      if (m_glitch < GMAX) m_glitch++;
    end
    #1;
    chk("dout", int'(dout), int'(m_level));
    chk("rise", int'(rise), int'(m_rise));
    chk("fall", int'(fall), int'(m_fall));
    chk("busy", int'(busy), int'(run > 0));
    chk("glitch_cnt", int'(glitch_cnt), m_glitch);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic edges_until_dout(input string tag, input logic lvl, input int exp);
    int n;
    n = 0;
    while (dout !== lvl && n < 30) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask
  initial begin
    int busy_n, rise_n, fall_n;
    logic seen;
    #1;
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_glitch", int'(glitch_cnt), 0);
    #21 rst = 1'b0;
    ticks(10);
    din = 1'b1;
    busy_n = 0;
    rise_n = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      busy_n += int'(busy);
      rise_n += int'(rise);
      if (i == 6) chk("rise_at_k6", int'(rise), 1);
    end
    chk("rise_dout", int'(dout), 1);
    chk("busy_cycles", busy_n, 4);
    tick();
    chk("rise_low_k7", int'(rise), 0);
    chk("rise_count", rise_n, 1);
    ticks(10);
    din = 1'b0;
    fall_n = 0;
    rise_n = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      fall_n += int'(fall);
      rise_n += int'(rise);
    end
    chk("fall_dout", int'(dout), 0);
    chk("fall_count", fall_n, 1);
    chk("fall_no_rise", rise_n, 0);
    ticks(10);
    din = 1'b1;
    ticks(3);
    din = 1'b0;
    ticks(10);
    chk("glitch_dout", int'(dout), 0);
    chk("glitch_one", int'(glitch_cnt), 1);
    din = 1'b1;
    ticks(3);
    chk("midq_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_glitch", int'(glitch_cnt), 0);
    model_reset();
    #2 rst = 1'b0;
    edges_until_dout("requal_edges", 1'b1, 7);
    din = 1'b0;
    edges_until_dout("requal_fall", 1'b0, 7);
    ticks(5);
    din = 1'b1;
    seen = 1'b0;
    ticks(DC);
    din = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= dout;
    end
    chk("pulse5_accepted", int'(seen), 1);
    ticks(5);
    din = 1'b1;
    seen = 1'b0;
    ticks(DC - 1);
    din = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= dout;
    end
    chk("pulse4_rejected", int'(seen), 0);
    chk("pulse4_glitch", int'(glitch_cnt), 1);
    for (int p = 0; p < 300; p++) begin
      din = 1'b1;
      ticks(2);
      din = 1'b0;
      ticks(3);
    end
    chk("glitch_saturated", int'(glitch_cnt), GMAX);
    for (int r = 0; r < 400; r++) begin
      din = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 8)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
